hilo_pipe: RTL and testbench
============================

Name: hilo_pipe

Overview:
- Downstream consumer of the EX-stage ALU's HI/LO results: `hi_alu_out`/`lo_alu_out`, with per-register write enables from decode.
- Carries pending HI/LO writes through MEM and WB pipeline slots and commits them to the architectural HI/LO registers.
- Cancels writes killed by flush or by a MEM-stage exception.
- Drives the forwarded HI/LO values back into the ALU's `hi_in`/`lo_in` for MFHI/MFLO.

Parameters:
- DW, 32, data width of HI and LO.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- ex_hi_we  input  1  EX instruction writes HI (MULT/MULTU/MTHI).
- ex_lo_we  input  1  EX instruction writes LO (MULT/MULTU/MTLO).
- ex_hi_i  input  DW  HI value from ALU.
- ex_lo_i  input  DW  LO value from ALU.
- ex_stall  input  1  EX not ready to advance (includes multiplier busy).
- ex_flush  input  1  EX instruction squashed.
- mem_stall  input  1  MEM stage held.
- mem_flush  input  1  MEM stage squashed (exception/eret redirect).
- mem_excepttype  input  32  nonzero = MEM instruction raises exception.
- hi_o  output  DW  forwarded HI for ALU `hi_in`.
- lo_o  output  DW  forwarded LO for ALU `lo_in`.
- arch_hi_o  output  DW  committed HI.
- arch_lo_o  output  DW  committed LO.
- hilo_busy_o  output  1  any valid pending write in MEM or WB slot.

Behaviour:
- State: MEM slot {m_hi_we, m_lo_we, m_hi, m_lo}; WB slot {w_hi_we, w_lo_we, w_hi, w_lo}; architectural HI, LO.
- Reset (async, rst_i=1): all write enables 0, all data regs 0. Outputs are then hi_o=lo_o=arch_hi_o=arch_lo_o=0 and hilo_busy_o=0.
- MEM slot update, priority high to low:
  - mem_flush: clear both enables.
  - mem_stall: hold the slot.
  - ex_stall or ex_flush: load a bubble (enables 0, data don't-care, hold recommended).
  - Otherwise: load the ex_* enables and data.
- A multiply result is captured only on the edge where ex_stall is low, i.e. after the multiplier reports ready.
- Exception kill: kill = (mem_excepttype != 0).
- WB slot update, priority high to low:
  - mem_flush, kill, or mem_stall: load a bubble. WB still drains while MEM holds.
  - Otherwise: load the MEM slot.
- Commit: on every edge, HI <= w_hi if w_hi_we; LO <= w_lo if w_lo_we. Commit is never blocked by stall or flush, because WB is past the exception point.
- Latency: an EX write becomes visible on hi_o/lo_o 1 cycle after capture (via MEM forward). It reaches arch_*_o 3 rising edges after the EX-capture cycle begins (EX->MEM, MEM->WB, WB->arch).
- Forwarding (combinational, per register independently):
  - hi_o = m_hi if (m_hi_we & ~kill);
  - else w_hi if w_hi_we;
  - else arch HI.
  - lo_o uses the same rule with the LO fields.
- An excepting MEM instruction is never forwarded.
- hilo_busy_o = (m_hi_we|m_lo_we)&~kill | w_hi_we | w_lo_we.
- Boundary conditions:
  - Back-to-back writes to the same register: the youngest (MEM) wins the forward.
  - HI-only followed by LO-only: each register forwards independently.
  - mem_flush and kill in the same cycle: identical result (both bubble WB).
  - Reset asserted mid-pipeline: all pending writes are lost and architectural HI/LO read 0.
  - ex_flush while mem_stall=1: MEM holds, EX input ignored.

Test Plan:
1. Reset release, then MTHI 0x1234_5678 with ex_stall=0 -> hi_o=0x12345678 next cycle, arch_hi_o=0x12345678 after 3 edges; lo_o/arch_lo_o stay 0.
2. MULT with ex_stall high for 9 cycles, then low with ex_hi_i=0xFFFF_FFFF, ex_lo_i=0xFFFF_FFFE -> no MEM capture during stall; after release, hi_o/lo_o forward 0xFFFFFFFF/0xFFFFFFFE next cycle; arch updates 2 edges later.
3. MTLO 0xA then MTLO 0xB on consecutive cycles -> lo_o=0xA then 0xB; arch_lo_o ends 0xB.
4. MTHI 0x55 in MEM with mem_excepttype=0x1 -> hi_o shows the previous arch value, WB gets a bubble, arch_hi_o never becomes 0x55, hilo_busy_o=0.
5. mem_stall=1 for 3 cycles with MTLO 0x77 in MEM -> MEM holds, WB bubbles, lo_o=0x77 throughout; after release, arch_lo_o=0x77 2 edges later.
6. rst_i asserted asynchronously between edges while a write sits in WB -> all outputs read 0 immediately; no commit on the following edge.

Source files
------------

// File: rtl/hilo_pipe_if.sv
// HI/LO pipeline bundle: EX-stage write requests, MEM-stage control,
// and the forwarded/committed HI/LO values returned to the ALU.
interface hilo_pipe_if #(
  parameter int DW = 32
);
  logic          ex_hi_we;
  logic          ex_lo_we;
  logic [DW-1:0] ex_hi_i;
  logic [DW-1:0] ex_lo_i;
  logic          ex_stall;
  logic          ex_flush;
  logic          mem_stall;
  logic          mem_flush;
  logic [31:0]   mem_excepttype;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
  logic [DW-1:0] arch_hi_o;
  logic [DW-1:0] arch_lo_o;
  logic          hilo_busy_o;

  modport master (
    output ex_hi_we, ex_lo_we, ex_hi_i, ex_lo_i,
    output ex_stall, ex_flush, mem_stall, mem_flush, mem_excepttype,
    input  hi_o, lo_o, arch_hi_o, arch_lo_o, hilo_busy_o
  );

  modport slave (
    input  ex_hi_we, ex_lo_we, ex_hi_i, ex_lo_i,
    input  ex_stall, ex_flush, mem_stall, mem_flush, mem_excepttype,
    output hi_o, lo_o, arch_hi_o, arch_lo_o, hilo_busy_o
  );
endinterface

// File: rtl/hilo_pipe.sv
// Carries HI/LO writes from EX through MEM and WB slots into the architectural
// HI/LO registers, cancelling killed writes and forwarding the youngest value.
module hilo_pipe #(
  parameter int DW = 32
) (
  input logic        clk_i,
  input logic        rst_i,
  hilo_pipe_if.slave bus
);

  typedef struct packed {
    logic          hi_we;
    logic          lo_we;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } slot_t;

  slot_t         mem_q, mem_d;
  slot_t         wb_q, wb_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic          kill;

  assign kill = |bus.mem_excepttype;

  // MEM slot: flush beats stall beats an EX bubble beats a normal load.
  always_comb begin
    // NOTE: default to the held value first so no path leaves mem_d unassigned (no latch).
    mem_d = mem_q;
    if (bus.mem_flush) begin
      mem_d.hi_we = 1'b0;
      mem_d.lo_we = 1'b0;
    end else if (bus.mem_stall) begin
      mem_d = mem_q;
    end else if (bus.ex_stall || bus.ex_flush) begin
      mem_d.hi_we = 1'b0;
      mem_d.lo_we = 1'b0;
    end else begin
      mem_d.hi_we = bus.ex_hi_we;
      mem_d.lo_we = bus.ex_lo_we;
      mem_d.hi    = bus.ex_hi_i;
      mem_d.lo    = bus.ex_lo_i;
    end
  end

  // WB slot keeps draining while MEM holds, so a stalled MEM sends a bubble.
  always_comb begin
    wb_d = mem_q;
    if (bus.mem_flush || kill || bus.mem_stall) begin
      wb_d       = wb_q;
      wb_d.hi_we = 1'b0;
      wb_d.lo_we = 1'b0;
    end
  end

  // WB is past the exception point, so commit ignores stall and flush.
  always_comb begin
    hi_d = wb_q.hi_we ? wb_q.hi : hi_q;
    lo_d = wb_q.lo_we ? wb_q.lo : lo_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: data fields are reset too, not just enables, so the architectural
      // registers read a defined 0 and nothing stale can ever be committed.
      mem_q <= '0;
      wb_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mem_q <= mem_d;
      wb_q  <= wb_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Youngest valid write wins; an excepting MEM instruction is never forwarded.
  always_comb begin
    bus.hi_o = hi_q;
    bus.lo_o = lo_q;
    if (wb_q.hi_we)              bus.hi_o = wb_q.hi;
    if (mem_q.hi_we && !kill)    bus.hi_o = mem_q.hi;
    if (wb_q.lo_we)              bus.lo_o = wb_q.lo;
    if (mem_q.lo_we && !kill)    bus.lo_o = mem_q.lo;
  end

  assign bus.arch_hi_o   = hi_q;
  assign bus.arch_lo_o   = lo_q;
  assign bus.hilo_busy_o = ((mem_q.hi_we || mem_q.lo_we) && !kill)
                           || wb_q.hi_we || wb_q.lo_we;

endmodule

// File: tb/tb_hilo_pipe.sv
// Self-checking bench for hilo_pipe: directed scenarios plus random traffic,
// compared against a queue-based model of in-flight HI/LO writes.
module tb_hilo_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hilo_pipe_if #(.DW(32)) bus ();

  hilo_pipe #(.DW(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Model: list of in-flight writes (oldest first), stage 0 = MEM, 1 = WB.
  typedef struct {
    int          stage;
    bit          hw;
    bit          lw;
    logic [31:0] h;
    logic [31:0] l;
  } op_t;

  op_t         pend[$];
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  function automatic void model_reset();
    pend.delete();
    ref_hi = '0;
    ref_lo = '0;
  endfunction

  function automatic void model_edge();
    op_t  nq[$];
    op_t  o;
    logic kill;
    kill = (bus.mem_excepttype != 32'd0);
    foreach (pend[i]) begin
      o = pend[i];
      if (o.stage == 1) begin
        if (o.hw) ref_hi = o.h;
        if (o.lw) ref_lo = o.l;
      end else if (bus.mem_flush) begin
        // squashed in MEM
      end else if (bus.mem_stall) begin
        nq.push_back(o);
      end else if (!kill) begin
        o.stage = 1;
        nq.push_back(o);
      end
    end
    if (!bus.mem_flush && !bus.mem_stall && !bus.ex_stall && !bus.ex_flush
        && (bus.ex_hi_we || bus.ex_lo_we)) begin
      o.stage = 0; o.hw = bus.ex_hi_we; o.lw = bus.ex_lo_we;
      o.h = bus.ex_hi_i; o.l = bus.ex_lo_i;
      nq.push_back(o);
    end
    pend = nq;
  endfunction

  // Expected {hi_o, lo_o, arch_hi_o, arch_lo_o, busy} from the model.
  function automatic logic [128:0] expect_vec();
    logic [31:0] h, l;
    logic        busy, kill;
    kill = (bus.mem_excepttype != 32'd0);
    h = ref_hi; l = ref_lo; busy = 1'b0;
    foreach (pend[i]) begin
      if (!(pend[i].stage == 0 && kill)) begin
        if (pend[i].hw) h = pend[i].h;
        if (pend[i].lw) l = pend[i].l;
        if (pend[i].hw || pend[i].lw) busy = 1'b1;
      end
    end
    return {h, l, ref_hi, ref_lo, busy};
  endfunction

  function automatic logic [128:0] observe();
    return {bus.hi_o, bus.lo_o, bus.arch_hi_o, bus.arch_lo_o, bus.hilo_busy_o};
  endfunction

  task automatic drive(input logic hwe, input logic lwe, input logic [31:0] h,
                       input logic [31:0] l, input logic exs, input logic exf,
                       input logic ms, input logic mf, input logic [31:0] et);
    @(negedge clk);
    bus.ex_hi_we = hwe; bus.ex_lo_we = lwe;
    bus.ex_hi_i = h; bus.ex_lo_i = l;
    bus.ex_stall = exs; bus.ex_flush = exf;
    bus.mem_stall = ms; bus.mem_flush = mf;
    bus.mem_excepttype = et;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'hBAD0_BAD0, 32'hBAD1_BAD1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    idle();
    #1;
    checks++;
    if (observe() !== 129'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", observe());
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    checks++;
    if (observe() !== expect_vec()) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", observe(), expect_vec());
    end
  endtask

  task automatic test_mthi();
    drive(1'b1, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checks++;
    if (bus.hi_o !== 32'h1234_5678 || bus.lo_o !== 32'd0) begin
      errors++;
      $display("FAIL mthi_fwd got=%h/%h exp=12345678/0", bus.hi_o, bus.lo_o);
    end
    idle(); tick();
    checks++;
    if (bus.arch_hi_o !== 32'd0) begin
      errors++;
      $display("FAIL mthi_early_commit got=%h exp=0", bus.arch_hi_o);
    end
    idle(); tick();
    checks++;
    if (bus.arch_hi_o !== 32'h1234_5678 || bus.arch_lo_o !== 32'd0) begin
      errors++;
      $display("FAIL mthi_arch got=%h/%h exp=12345678/0", bus.arch_hi_o, bus.arch_lo_o);
    end
  endtask

  task automatic test_mult_stall();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 32'hDEAD_0000 + i, 32'hBEEF_0000 + i, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      checks++;
      if (observe() !== expect_vec() || bus.hi_o !== 32'h1234_5678) begin
        errors++;
        $display("FAIL mult_stall cyc=%0d got=%h exp=%h", i, observe(), expect_vec());
      end
    end
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checks++;
    if (bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mult_fwd got=%h/%h exp=ffffffff/fffffffe", bus.hi_o, bus.lo_o);
    end
    idle(); tick();
    idle(); tick();
    checks++;
    if (bus.arch_hi_o !== 32'hFFFF_FFFF || bus.arch_lo_o !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mult_arch got=%h/%h exp=ffffffff/fffffffe", bus.arch_hi_o, bus.arch_lo_o);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 32'h0, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checks++;
    if (bus.lo_o !== 32'hA) begin
      errors++;
      $display("FAIL b2b_first got=%h exp=a", bus.lo_o);
    end
    drive(1'b0, 1'b1, 32'h0, 32'hB, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checks++;
    if (bus.lo_o !== 32'hB || bus.hi_o !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL b2b_second got=%h/%h exp=ffffffff/b", bus.hi_o, bus.lo_o);
    end
    for (int i = 0; i < 3; i++) begin idle(); tick(); end
    checks++;
    if (bus.arch_lo_o !== 32'hB || bus.hilo_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_arch got=%h busy=%b exp=b busy=0", bus.arch_lo_o, bus.hilo_busy_o);
    end
  endtask

  task automatic test_exception_kill();
    drive(1'b1, 1'b0, 32'h55, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1);
    #1;
    checks++;
    if (bus.hi_o !== 32'hFFFF_FFFF || bus.hilo_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_fwd got=%h busy=%b exp=ffffffff busy=0", bus.hi_o, bus.hilo_busy_o);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); tick();
      checks++;
      if (bus.arch_hi_o === 32'h55 || observe() !== expect_vec()) begin
        errors++;
        $display("FAIL kill_arch cyc=%0d got=%h exp=%h", i, observe(), expect_vec());
      end
    end
  endtask

  task automatic test_mem_stall();
    drive(1'b0, 1'b1, 32'h0, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      // EX flush while MEM is held must be ignored
      drive(1'b1, 1'b1, 32'h99, 32'h99, 1'b0, (i == 1), 1'b1, 1'b0, 32'd0);
      tick();
      checks++;
      if (bus.lo_o !== 32'h77 || bus.arch_lo_o !== 32'hB) begin
        errors++;
        $display("FAIL mem_stall cyc=%0d got=%h arch=%h exp=77 arch=b", i, bus.lo_o, bus.arch_lo_o);
      end
    end
    idle(); tick();
    idle(); tick();
    checks++;
    if (bus.arch_lo_o !== 32'h77 || bus.arch_hi_o !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mem_stall_arch got=%h/%h exp=ffffffff/77", bus.arch_hi_o, bus.arch_lo_o);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    idle(); tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (observe() !== 129'd0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=0", observe());
    end
    @(posedge clk); #1;
    checks++;
    if (observe() !== 129'd0) begin
      errors++;
      $display("FAIL reset_no_commit got=%h exp=0", observe());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] et;
    for (int i = 0; i < 400; i++) begin
      et = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h1) : 32'd0;
      drive(1'($urandom), 1'($urandom), $urandom, $urandom,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), et);
      #1;
      checks++;
      if (observe() !== expect_vec()) begin
        errors++;
        $display("FAIL random_comb cyc=%0d got=%h exp=%h", i, observe(), expect_vec());
      end
      tick();
      checks++;
      if (observe() !== expect_vec()) begin
        errors++;
        $display("FAIL random_edge cyc=%0d got=%h exp=%h", i, observe(), expect_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mthi();
    test_mult_stall();
    test_back_to_back();
    test_exception_kill();
    test_mem_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
